// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared FSM state encoding and parameter defaults for the io_bridge block.
package io_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAM_ACC,
        RAM_RD,
        IO_STB,
        IO_WAIT,
        DONE
    } state_e;

    localparam logic [7:0]  DEFAULT_IO_PAGE = 8'hFF;
    localparam int unsigned DEFAULT_TMO     = 15;

endpackage

// File: rtl/io_bridge_decode.sv
// io_bridge_decode: combinational address decode into RAM window, IO channel, or unmapped channel.
module io_bridge_decode
    import io_bridge_pkg::*;
#(
    parameter int         AW      = 16,
    parameter int         NCH     = 4,
    parameter logic [7:0] IO_PAGE = DEFAULT_IO_PAGE
) (
    input  logic [AW-1:0] addr_i,
    output logic          is_io_o,
    output logic [3:0]    channel_o,
    output logic          unmapped_o
);

    // Only the page byte and the channel nibble matter here; the rest feeds the targets directly.
    logic unusedAddr;
    assign unusedAddr = ^addr_i;

    always_comb begin
        is_io_o    = (addr_i[AW-1:AW-8] == IO_PAGE);
        channel_o  = addr_i[7:4];
        unmapped_o = is_io_o && ({1'b0, channel_o} >= 5'(NCH));
    end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: routes CPU requests to a synchronous RAM or to one of NCH byte-wide IO channels.
// Define IO_BRIDGE_TIMEOUT_EN to abort IO accesses that see no ack within TMO wait cycles.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int         DW      = 16,
    parameter int         AW      = 16,
    parameter int         NCH     = 4,
    parameter int         TMO     = DEFAULT_TMO,
    parameter logic [7:0] IO_PAGE = DEFAULT_IO_PAGE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    input  logic [DW/8-1:0]    cpu_be,
    input  logic               cpu_we,
    input  logic               cpu_re,
    output logic [DW-1:0]      cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_wdata,
    output logic [DW/8-1:0]    ram_be,
    output logic               ram_we,
    input  logic [DW-1:0]      ram_rdata,
    output logic [2:0]         io_addr,
    output logic [7:0]         io_wdata,
    output logic [NCH-1:0]     io_we,
    output logic [NCH-1:0]     io_re,
    input  logic [8*NCH-1:0]   io_rdata,
    input  logic [NCH-1:0]     io_ack
);

    state_e          state_q, state_d;
    logic            isWrite_q, isWrite_d;
    logic [3:0]      chan_q, chan_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            isIo;
    logic [3:0]      chanDec;
    logic            unmapped;
    logic            ackSel;
    logic [7:0]      ioByte;

`ifdef IO_BRIDGE_TIMEOUT_EN
    logic [7:0]      tmoCnt_q, tmoCnt_d;
`endif

    io_bridge_decode #(
        .AW      (AW),
        .NCH     (NCH),
        .IO_PAGE (IO_PAGE)
    ) u_decode (
        .addr_i     (cpu_addr),
        .is_io_o    (isIo),
        .channel_o  (chanDec),
        .unmapped_o (unmapped)
    );

    // Acks and read bytes from channels other than the latched one never reach the FSM.
    always_comb begin
        ackSel = 1'b0;
        ioByte = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan_q == 4'(i)) begin
                ackSel = io_ack[i];
                ioByte = io_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        isWrite_d = isWrite_q;
        chan_d    = chan_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
        tmoCnt_d  = tmoCnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (cpu_we || cpu_re) begin
                    isWrite_d = cpu_we;
                    chan_d    = chanDec;
                    err_d     = 1'b0;
                    if (!isIo) begin
                        state_d = RAM_ACC;
                    end else if (unmapped) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!cpu_we) begin
                            rdata_d = '1;
                        end
                    end else begin
                        state_d = IO_STB;
`ifdef IO_BRIDGE_TIMEOUT_EN
                        tmoCnt_d = '0;
`endif
                    end
                end
            end

            RAM_ACC: begin
                state_d = isWrite_q ? DONE : RAM_RD;
            end

            RAM_RD: begin
                rdata_d = ram_rdata;
                state_d = DONE;
            end

            IO_STB, IO_WAIT: begin
                if (ackSel) begin
                    state_d = DONE;
                    if (!isWrite_q) begin
                        rdata_d      = '0;
                        rdata_d[7:0] = ioByte;
                    end
                end else begin
                    state_d = IO_WAIT;
`ifdef IO_BRIDGE_TIMEOUT_EN
                    // An ack in the final wait cycle is taken above, so it beats the timeout.
                    if (state_q == IO_WAIT) begin
                        tmoCnt_d = tmoCnt_q + 8'd1;
                        if (tmoCnt_d == 8'(TMO)) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                            if (!isWrite_q) begin
                                rdata_d = '1;
                            end
                        end
                    end
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            isWrite_q <= 1'b0;
            chan_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            tmoCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            isWrite_q <= isWrite_d;
            chan_q    <= chan_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
            tmoCnt_q  <= tmoCnt_d;
`endif
        end
    end

    // The CPU holds its request stable until ready, so address and data pass straight through.
    always_comb begin
        cpu_rdata = rdata_q;
        cpu_ready = (state_q == DONE);
        cpu_err   = (state_q == DONE) && err_q;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_be    = cpu_be;
        ram_we    = (state_q == RAM_ACC) && isWrite_q;
        io_addr   = cpu_addr[2:0];
        io_wdata  = cpu_wdata[7:0];
        io_we     = '0;
        io_re     = '0;
        for (int i = 0; i < NCH; i++) begin
            io_we[i] = (state_q == IO_STB) && isWrite_q  && (chan_q == 4'(i));
            io_re[i] = (state_q == IO_STB) && !isWrite_q && (chan_q == 4'(i));
        end
    end

endmodule
